input_buffer: RTL and testbench

//  Per-port packet FIFO placed ahead of the router controller, one per input (N,S,E,W,L).
//  - Accepts packets from the upstream link.
//  - Presents the head packet to the controller's routing logic: address byte and valid flag.
//  - Removes the head when the controller pops it.
//  - Drives the full status that the upstream router's arbiter samples as buffer_full_in.

---
 rtl/input_buffer.sv | 101 ++++++++++
 tb/tb_input_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/input_buffer.sv
// input_buffer: per-port packet FIFO ahead of the router controller.
// First-word fall-through head, registered full/almost-full, sticky errors.
module input_buffer #(
  parameter int PKT_W    = 32,
  parameter int DEPTH    = 4,
  parameter int ADDR_LSB = 24,
  parameter int AF_LVL   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [PKT_W-1:0]           data_i,
  input  logic                       pop_i,
  output logic [PKT_W-1:0]           data_o,
  output logic                       packet_valid_o,
  output logic [7:0]                 packet_addr_o,
  output logic                       full_o,
  output logic                       almost_full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [1:0]                 err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] P_ONE  = AW'(1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_ZERO = '0;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF   = CW'(AF_LVL);

  logic [PKT_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          full_q;
  logic          af_q;
  logic [1:0]    err_q;

  logic          pop_acc;
  logic          push_acc;

  assign pop_acc  = pop_i && (count_q != C_ZERO);
  assign push_acc = push_i && ((count_q != C_FULL) || pop_acc);

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    count_next = count_q;
    unique case (1'b1)
      push_acc && !pop_acc: count_next = count_q + C_ONE;
      pop_acc && !push_acc: count_next = count_q - C_ONE;
      default:              count_next = count_q;
    endcase
  end

  // Packet storage; not reset, contents are ignored while empty.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers, occupancy, registered flags and sticky error bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + P_ONE;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + P_ONE;
      end
      count_q <= count_next;
      full_q  <= (count_next == C_FULL);
      af_q    <= (count_next >= C_AF);
      if (push_i && !push_acc) begin
        err_q[1] <= 1'b1;
      end
      if (pop_i && (count_q == C_ZERO)) begin
        err_q[0] <= 1'b1;
      end
    end
  end

  assign data_o         = mem[rd_ptr];
  assign packet_addr_o  = data_o[ADDR_LSB +: 8];
  assign packet_valid_o = (count_q != C_ZERO);
  assign full_o         = full_q;
  assign almost_full_o  = af_q;
  assign count_o        = count_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_input_buffer.sv
// tb_input_buffer: vector table plus scoreboard for input_buffer.
// Random phase wraps pointers; reset cases checked asynchronously.
module tb_input_buffer;

  logic        clk;
  logic        rst;
  logic        push_i;
  logic [31:0] data_i;
  logic        pop_i;
  logic [31:0] data_o;
  logic        packet_valid_o;
  logic [7:0]  packet_addr_o;
  logic        full_o;
  logic        almost_full_o;
  logic [2:0]  count_o;
  logic [1:0]  err_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  logic [1:0]  exp_err;

  input_buffer #(
    .PKT_W(32), .DEPTH(4), .ADDR_LSB(24), .AF_LVL(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .push_i(push_i),
    .data_i(data_i),
    .pop_i(pop_i),
    .data_o(data_o),
    .packet_valid_o(packet_valid_o),
    .packet_addr_o(packet_addr_o),
    .full_o(full_o),
    .almost_full_o(almost_full_o),
    .count_o(count_o),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    bit          push;
    logic [31:0] data;
    bit          pop;
    int          cnt;
    bit          valid;
    bit          full;
    bit          af;
    logic [1:0]  err;
    logic [31:0] head;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse reset between edges and clear the model.
  task automatic do_reset();
    push_i = 1'b0;
    pop_i  = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    sb.delete();
    exp_err = 2'b00;
  endtask

  // One clock with scoreboard bookkeeping; called just after an edge.
  task automatic cycle(input bit push, input logic [31:0] d,
                       input bit pop);
    bit pacc;
    bit wacc;
    push_i = push;
    data_i = d;
    pop_i  = pop;
    pacc = pop && (sb.size() != 0);
    wacc = push && ((sb.size() != 4) || pacc);
    if (pop && sb.size() == 0) exp_err[0] = 1'b1;
    if (push && !wacc) exp_err[1] = 1'b1;
    #2;
    if (pacc) begin
      chk("sb_head", data_o, sb[0]);
      void'(sb.pop_front());
    end
    if (wacc) sb.push_back(d);
    @(posedge clk);
    #1;
    push_i = 1'b0;
    pop_i  = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, 32'(count_o), 32'(sb.size()));
    chk({tag, "_valid"}, 32'(packet_valid_o), 32'(sb.size() != 0));
    chk({tag, "_full"}, 32'(full_o), 32'(sb.size() == 4));
    chk({tag, "_af"}, 32'(almost_full_o), 32'(sb.size() >= 3));
    chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
  endtask

  initial begin
    vecs[0]  = '{0,1,32'hA1000001,0, 1,1,0,0,2'b00,32'hA1000001};
    vecs[1]  = '{0,1,32'hB2000002,0, 2,1,0,0,2'b00,32'hA1000001};
    vecs[2]  = '{0,1,32'hC3000003,0, 3,1,0,1,2'b00,32'hA1000001};
    vecs[3]  = '{0,1,32'hD4000004,0, 4,1,1,1,2'b00,32'hA1000001};
    vecs[4]  = '{0,1,32'hE5000005,0, 4,1,1,1,2'b10,32'hA1000001};
    vecs[5]  = '{0,1,32'hF6000006,1, 4,1,1,1,2'b10,32'hB2000002};
    vecs[6]  = '{0,0,32'h0,       1, 3,1,0,1,2'b10,32'hC3000003};
    vecs[7]  = '{0,0,32'h0,       1, 2,1,0,0,2'b10,32'hD4000004};
    vecs[8]  = '{0,0,32'h0,       1, 1,1,0,0,2'b10,32'hF6000006};
    vecs[9]  = '{0,0,32'h0,       1, 0,0,0,0,2'b10,32'h0};
    vecs[10] = '{1,0,32'h0,       1, 0,0,0,0,2'b01,32'h0};
    vecs[11] = '{0,1,32'h12345678,1, 1,1,0,0,2'b01,32'h12345678};
    vecs[12] = '{0,0,32'h0,       1, 0,0,0,0,2'b01,32'h0};

    rst = 1'b0;
    push_i = 1'b0;
    pop_i = 1'b0;
    data_i = '0;
    exp_err = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_valid", 32'(packet_valid_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_af", 32'(almost_full_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_rst) do_reset();
      cycle(vecs[i].push, vecs[i].data, vecs[i].pop);
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_valid", i), 32'(packet_valid_o),
          32'(vecs[i].valid));
      chk($sformatf("v%0d_full", i), 32'(full_o), 32'(vecs[i].full));
      chk($sformatf("v%0d_af", i), 32'(almost_full_o), 32'(vecs[i].af));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].err));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_data", i), data_o, vecs[i].head);
        chk($sformatf("v%0d_addr", i), 32'(packet_addr_o),
            32'(vecs[i].head[31:24]));
      end
    end

    do_reset();
    for (int i = 0; i < 48; i++) begin
      bit pu;
      bit po;
      pu = ($urandom_range(0, 99) < 60);
      po = ($urandom_range(0, 99) < 45);
      cycle(pu, $urandom, po);
      chk_state($sformatf("r%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        chk_state($sformatf("g%0d", i));
      end
    end
    while (sb.size() != 0) begin
      cycle(1'b0, 32'h0, 1'b1);
      chk_state("drain");
    end

    do_reset();
    cycle(1'b1, 32'h11000001, 1'b0);
    cycle(1'b1, 32'h22000002, 1'b0);
    cycle(1'b1, 32'h33000003, 1'b0);
    chk("pre_rst_count", 32'(count_o), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_count", 32'(count_o), 32'd0);
    chk("async_valid", 32'(packet_valid_o), 32'd0);
    chk("async_full", 32'(full_o), 32'd0);
    chk("async_af", 32'(almost_full_o), 32'd0);
    #2;
    rst = 1'b1;
    sb.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
